serial_addsub: RTL and testbench
================================

# serial_addsub

Multi-cycle, digit-serial adder/subtractor for the calculator datapath. It generalises the one-bit full-adder cell to a parametrised WIDTH operand, processed DIGIT bits per clock. It exposes a start/ready/done handshake and carry, overflow and zero flags. It sits between the operand registers and the result/display path, and trades latency for a DIGIT-bit carry chain.

## Interface
- WIDTH, default 8: operand and result width in bits. Must be at least 2.
- DIGIT, default 1: bits processed per cycle. WIDTH must be a multiple of DIGIT (elaboration-time assertion).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request. Accepted only on a rising edge where ready=1.
- sub  in  1  0 = a+b, 1 = a-b. Sampled with start.
- a  in  WIDTH  operand A. Sampled with start.
- b  in  WIDTH  operand B. Sampled with start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse marking a valid, newly written result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of MSB. For sub, 1 means no borrow.
- ovf  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

## Operation
- Let N = WIDTH/DIGIT. The FSM has three states: IDLE, RUN, DONE.
- IDLE: ready=1. On start, load:
  - shift register A with a;
  - shift register B with b, or with ~b when sub=1;
  - carry with sub;
  - digit counter with 0.
  - Then go to RUN.
  - start with ready=0 is ignored and not queued.
- RUN: each edge does the following.
  - Add the low DIGIT bits of A and B plus carry.
  - Shift the DIGIT sum bits into the top of the result shift register.
  - Shift A and B right by DIGIT.
  - Update carry and increment the counter.
  - On the edge where counter == N-1 completes, go to DONE.
- DONE: lasts one cycle.
  - done=1.
  - sum, cout, ovf and zero are written from the finished result on the RUN→DONE edge.
  - Next state is IDLE unconditionally.
- Flag rules:
  - cout = final carry.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]), where b' is the effective B (inverted for sub).
  - zero = ~|sum.
- Output registers hold their values until the next completed operation; they do not change during RUN.
- Operands changing after acceptance have no effect.
- Reset at any time, including mid-RUN, aborts the operation: no done pulse, all outputs return to their reset values.

## Timing
- Reset values: state=IDLE, ready=1, done=0, sum=0, cout=0, ovf=0, zero=0. Internal shift registers, carry and counter are all 0.
- Start accepted at edge t:
  - ready=0 from t to t+N+1;
  - results visible and done=1 after edge t+N;
  - done=0 and ready=1 after edge t+N+1.
- Latency: N+1 cycles start→done; throughput is one operation per N+2 cycles.
- Back-to-back: start held high gets the next operation accepted at edge t+N+2.
- DIGIT == WIDTH (N=1) is legal: done follows one cycle after RUN.
- Combinational depth per cycle is one DIGIT-bit ripple. No combinational path exists from inputs to outputs.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the op encoding constants OP_ADD=0 and OP_SUB=1;
  - the helper function computing ovf from the three MSBs.
- Sub-module digit_adder (parameter DIGIT): purely combinational DIGIT-bit ripple of one-bit full-adder cells. Inputs are x, y and cin; outputs are s and cout. It is instantiated once.
- Top-level holds the FSM, counter (width $clog2(N)+1), shift registers and output registers.

## Test plan
- WIDTH=8, DIGIT=1: a=8'h2C, b=8'h17, sub=0 → after 9 cycles done pulse. Expected: sum=8'h43, cout=0, ovf=0, zero=0. ready low for exactly 9 cycles.
- WIDTH=8, DIGIT=1: a=8'h05, b=8'h05, sub=1 → sum=8'h00, cout=1, ovf=0, zero=1. Then a=8'h03, b=8'h05, sub=1 → sum=8'hFE, cout=0, ovf=0.
- WIDTH=8, DIGIT=4: a=8'h7F, b=8'h01, sub=0 → done after 3 cycles, sum=8'h80, ovf=1, cout=0. Then a=8'h80, b=8'h01, sub=1 → sum=8'h7F, ovf=1, cout=1.
- Handshake: pulse start again during RUN with different operands → ignored, first result unchanged. Hold start high → second op accepted exactly N+2 cycles after the first; outputs stable between done pulses.
- Reset: assert rst_n=0 asynchronously mid-RUN (between clock edges) → outputs at reset values immediately, no done pulse. After release, a new op completes correctly.
- Random: 2000 operations at WIDTH=16 with DIGIT ∈ {1,2,4,16}, compared against a behavioural model for sum, cout, ovf and zero, with random start gaps.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the FSM state encoding, the op select values and the overflow rule.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: equal operand signs, result sign differs.
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder built from one-bit full-adder cells.
// This is the only carry chain in the datapath, so it sets the cycle time.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ c[i];
    assign c[i + 1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// start/ready/done handshake with registered sum, carry, overflow and zero flags.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N) + 1;

  if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             a_msb;
  logic             b_msb;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             last;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_sr[DIGIT-1:0]),
    .y    (b_sr[DIGIT-1:0]),
    .cin  (carry),
    .s    (dsum),
    .cout (dcout)
  );

  // New digits enter at the top so the LSB digit ends up at bit 0 after N steps.
  if (DIGIT == WIDTH) begin : g_single
    assign res_next = dsum;
  end else begin : g_multi
    assign res_next = {dsum, res_sr[WIDTH-1:DIGIT]};
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    done  = (state == DONE);
  end

  // Subtraction is a + ~b + 1, so the carry-in is preloaded with the op bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1] ^ (sub == OP_SUB);
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          carry  <= dcout;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum  <= res_next;
            cout <= dcout;
            ovf  <= calc_ovf(a_msb, b_msb, res_next[WIDTH-1]);
            zero <= ~|res_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Testbench for serial_addsub: six instances (8-bit D=1/4, 16-bit D=1/2/4/16)
// checked every cycle against an arithmetic model, plus directed literal checks.
module tb_serial_addsub;

  localparam int NI = 6;

  function automatic int wof(input int i);
    return (i < 2) ? 8 : 16;
  endfunction

  function automatic int dof(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      2:       return 1;
      3:       return 2;
      4:       return 4;
      default: return 16;
    endcase
  endfunction

  function automatic int nof(input int i);
    return wof(i) / dof(i);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [NI];
  logic        sub_v   [NI];
  logic [15:0] a_v     [NI];
  logic [15:0] b_v     [NI];
  logic        ready_v [NI];
  logic        done_v  [NI];
  logic        cout_v  [NI];
  logic        ovf_v   [NI];
  logic        zero_v  [NI];
  logic [15:0] sum_v   [NI];

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gd
    localparam int W = wof(g);
    localparam int D = dof(g);
    logic [W-1:0] s;
    serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .sub   (sub_v[g]),
      .a     (a_v[g][W-1:0]),
      .b     (b_v[g][W-1:0]),
      .ready (ready_v[g]),
      .done  (done_v[g]),
      .sum   (s),
      .cout  (cout_v[g]),
      .ovf   (ovf_v[g]),
      .zero  (zero_v[g])
    );
    assign sum_v[g] = 16'(s);
  end

  // Reference arithmetic: plain unsigned and signed integer math on the operands.
  function automatic void model_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic s, output logic [15:0] rs, output logic rc,
                                   output logic ro);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint av   = longint'(a) & m;
    longint bv   = longint'(b) & m;
    longint r, sa, sb, sr;
    if (s) begin
      r  = av - bv;
      rc = (av >= bv);
    end else begin
      r  = av + bv;
      rc = (r > m);
    end
    rs = 16'(r & m);
    sa = (av >= half) ? av - 2 * half : av;
    sb = (bv >= half) ? bv - 2 * half : bv;
    sr = s ? sa - sb : sa + sb;
    ro = (sr < -half) || (sr > half - 1);
  endfunction

  int          cyc;
  int          acc     [NI];
  int          ops     [NI];
  logic        e_ready [NI];
  logic        e_done  [NI];
  logic        e_cout  [NI];
  logic        e_ovf   [NI];
  logic        e_zero  [NI];
  logic [15:0] e_sum   [NI];
  logic [15:0] p_sum   [NI];
  logic        p_cout  [NI];
  logic        p_ovf   [NI];

  // Timeline model: an op accepted at edge t shows its result at t+N and frees at t+N+1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < NI; i++) begin
        acc[i]     = -1;
        e_ready[i] = 1'b1;
        e_done[i]  = 1'b0;
        e_sum[i]   = '0;
        e_cout[i]  = 1'b0;
        e_ovf[i]   = 1'b0;
        e_zero[i]  = 1'b0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < NI; i++) begin
        if (acc[i] >= 0 && cyc == acc[i] + nof(i) + 1) begin
          acc[i]    = -1;
          e_done[i] = 1'b0;
        end else if (acc[i] >= 0 && cyc == acc[i] + nof(i)) begin
          e_done[i] = 1'b1;
          e_sum[i]  = p_sum[i];
          e_cout[i] = p_cout[i];
          e_ovf[i]  = p_ovf[i];
          e_zero[i] = (p_sum[i] == 16'h0);
          ops[i]++;
        end else if (acc[i] < 0 && start_v[i]) begin
          acc[i] = cyc;
          model_op(wof(i), a_v[i], b_v[i], sub_v[i], p_sum[i], p_cout[i], p_ovf[i]);
        end
        e_ready[i] = (acc[i] < 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [20:0] act;
    logic [20:0] expv;
    for (int i = 0; i < NI; i++) begin
      act  = {ready_v[i], done_v[i], cout_v[i], ovf_v[i], zero_v[i], sum_v[i]};
      expv = {e_ready[i], e_done[i], e_cout[i], e_ovf[i], e_zero[i], e_sum[i]};
      compared++;
      if (act !== expv) begin
        mismatched++;
        $display("[TB] FAIL cycle_check[%0d] t=%0t: rdy/done/cout/ovf/zero/sum got %b/%b/%b/%b/%b/%h required %b/%b/%b/%b/%b/%h",
                 i, $time, act[20], act[19], act[18], act[17], act[16], act[15:0],
                 expv[20], expv[19], expv[18], expv[17], expv[16], expv[15:0]);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic reportTimeout(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout required event within bound", name);
  endtask

  task automatic waitDone(input int idx, output int n);
    n = 0;
    while (!done_v[idx] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) reportTimeout("wait_done");
  endtask

  // One operation: issue start for one cycle, then measure latency and ready-low span.
  task automatic applyStimulus(input int idx, input logic [15:0] av, input logic [15:0] bv,
                               input logic s, output int lat, output int lowcnt);
    int k;
    k = 0;
    while (!ready_v[idx] && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) reportTimeout("wait_ready");
    a_v[idx]     = av;
    b_v[idx]     = bv;
    sub_v[idx]   = s;
    start_v[idx] = 1'b1;
    @(negedge clk);
    start_v[idx] = 1'b0;
    a_v[idx]     = 16'($urandom);
    b_v[idx]     = 16'($urandom);
    sub_v[idx]   = 1'($urandom);
    lat    = 1;
    lowcnt = ready_v[idx] ? 0 : 1;
    while (!done_v[idx] && lat < 200) begin
      @(negedge clk);
      lat++;
      if (!ready_v[idx]) lowcnt++;
    end
    if (lat >= 200) reportTimeout("op_done");
    @(negedge clk);
    if (!ready_v[idx]) lowcnt++;
  endtask

  initial begin
    int          lat, low, n, n2, k;
    logic        stable;
    logic [15:0] hold;

    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      sub_v[i]   = 1'b0;
      a_v[i]     = '0;
      b_v[i]     = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(ready_v[0]), 32'd1);
    checkOutput("rst_done", 32'(done_v[0]), 32'd0);
    checkOutput("rst_sum", 32'(sum_v[0]), 32'h0);
    checkOutput("rst_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(0, 16'h2C, 16'h17, 1'b0, lat, low);
    checkOutput("add_latency", lat, 9);
    checkOutput("add_ready_low", low, 9);
    checkOutput("add_sum", 32'(sum_v[0]), 32'h43);
    checkOutput("add_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'b000);
    checkOutput("model_add_sum", 32'(e_sum[0]), 32'h43);

    applyStimulus(0, 16'h05, 16'h05, 1'b1, lat, low);
    checkOutput("sub_eq_sum", 32'(sum_v[0]), 32'h00);
    checkOutput("sub_eq_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'b101);

    applyStimulus(0, 16'h03, 16'h05, 1'b1, lat, low);
    checkOutput("sub_neg_sum", 32'(sum_v[0]), 32'hFE);
    checkOutput("sub_neg_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'b000);
    checkOutput("model_sub_neg_sum", 32'(e_sum[0]), 32'hFE);

    applyStimulus(1, 16'h7F, 16'h01, 1'b0, lat, low);
    checkOutput("d4_latency", lat, 3);
    checkOutput("d4_add_sum", 32'(sum_v[1]), 32'h80);
    checkOutput("d4_add_flags", {29'd0, cout_v[1], ovf_v[1], zero_v[1]}, 32'b010);
    checkOutput("model_d4_ovf", 32'(e_ovf[1]), 32'd1);

    applyStimulus(1, 16'h80, 16'h01, 1'b1, lat, low);
    checkOutput("d4_sub_sum", 32'(sum_v[1]), 32'h7F);
    checkOutput("d4_sub_flags", {29'd0, cout_v[1], ovf_v[1], zero_v[1]}, 32'b110);

    // A start pulse during RUN must be dropped, not queued.
    a_v[0] = 16'h2C; b_v[0] = 16'h17; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    a_v[0] = 16'h11; b_v[0] = 16'h22; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    waitDone(0, n);
    checkOutput("ignored_start_sum", 32'(sum_v[0]), 32'h43);
    @(negedge clk);
    checkOutput("ignored_start_ready", 32'(ready_v[0]), 32'd1);

    // Start held high: second op accepted N+2 cycles after the first.
    a_v[0] = 16'h01; b_v[0] = 16'h02; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    a_v[0] = 16'h10; b_v[0] = 16'h20;
    waitDone(0, n);
    checkOutput("b2b_first_sum", 32'(sum_v[0]), 32'h03);
    hold   = sum_v[0];
    stable = 1'b1;
    n2     = 0;
    do begin
      @(negedge clk);
      n2++;
      if (!done_v[0] && sum_v[0] != hold) stable = 1'b0;
    end while (!done_v[0] && n2 < 200);
    start_v[0] = 1'b0;
    checkOutput("b2b_spacing", n2, 10);
    checkOutput("b2b_stable", 32'(stable), 32'd1);
    checkOutput("b2b_second_sum", 32'(sum_v[0]), 32'h30);
    repeat (2) @(negedge clk);

    // Asynchronous reset between edges aborts a running op.
    a_v[0] = 16'h2C; b_v[0] = 16'h17; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(ready_v[0]), 32'd1);
    checkOutput("abort_done", 32'(done_v[0]), 32'd0);
    checkOutput("abort_sum", 32'(sum_v[0]), 32'h0);
    checkOutput("abort_flags", {29'd0, cout_v[0], ovf_v[0], zero_v[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(0, 16'h05, 16'h05, 1'b0, lat, low);
    checkOutput("post_reset_latency", lat, 9);
    checkOutput("post_reset_sum", 32'(sum_v[0]), 32'h0A);

    // Random traffic on the 16-bit instances with random start gaps.
    k = 0;
    while ((ops[2] < 500 || ops[3] < 500 || ops[4] < 500 || ops[5] < 500) && k < 40000) begin
      for (int i = 2; i < NI; i++) begin
        start_v[i] = ($urandom_range(0, 2) == 0);
        a_v[i]     = 16'($urandom);
        b_v[i]     = 16'($urandom);
        sub_v[i]   = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    if (k >= 40000) reportTimeout("random_ops");
    for (int i = 2; i < NI; i++) start_v[i] = 1'b0;
    repeat (25) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
